// File: rtl/cpu_pkg.sv
// Shared pipeline-control types for the 5-stage core:
// forwarding encodings, hazard FSM states and shadow metadata.
package cpu_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  localparam logic [1:0] FWD_RF   = 2'd0;
  localparam logic [1:0] FWD_EXME = 2'd1;
  localparam logic [1:0] FWD_MEWB = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             use_rs;
    logic             use_rt;
    logic [REG_W-1:0] dest;
    logic             reg_write;
    logic             mem_read;
  } shadow_t;

endpackage

// File: rtl/hazard_match.sv
// Compares both sources of a consumer against one producer entry.
// hit[0] is the rs match, hit[1] the rt match.
module hazard_match
  import cpu_pkg::*;
(
  input  shadow_t    cons,
  input  shadow_t    prod,
  output logic [1:0] hit
);

  logic wr_ok;
  logic unused_ok;

  assign wr_ok = prod.valid && prod.reg_write;

  assign hit[0] = wr_ok && cons.use_rs &&
                  cons.rs == prod.dest &&
                  cons.rs != REG_ZERO;

  assign hit[1] = wr_ok && cons.use_rt &&
                  cons.rt == prod.dest &&
                  cons.rt != REG_ZERO;

  assign unused_ok = ^{cons.valid, cons.dest,
                       cons.reg_write, cons.mem_read,
                       prod.rs, prod.rt, prod.use_rs,
                       prod.use_rt, prod.mem_read};

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Stall, flush and forwarding control for the 5-stage core,
// tracking in-flight metadata in a shadow pipeline.
module hazard_ctrl_unit
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_W     = 5,
  parameter int FORWARDING     = 1,
  parameter int LOAD_STALL_CYC = 1,
  parameter int BRANCH_STAGE   = 3,
  parameter int CNT_W          = 16
)(
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  enable,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  br_taken,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  ex_me_flush,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  busy,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  state_e  state;
  shadow_t s_idex, s_exme, s_mewb, id_ent;

  logic [1:0] hit_id_idex, hit_id_exme, hit_id_mewb;
  logic [1:0] hit_fw_exme, hit_fw_mewb;
  logic run, stall, flush, hold, go, stall_go, empty;

  always_comb begin
    id_ent = '0;
    if (id_valid) begin
      id_ent.valid     = 1'b1;
      id_ent.rs        = REG_W'(id_rs);
      id_ent.rt        = REG_W'(id_rt);
      id_ent.use_rs    = id_use_rs;
      id_ent.use_rt    = id_use_rt;
      id_ent.dest      = REG_W'(id_dest);
      id_ent.reg_write = id_reg_write;
      id_ent.mem_read  = id_mem_read;
    end
  end

  hazard_match u_id_idex (
    .cons(id_ent), .prod(s_idex), .hit(hit_id_idex));
  hazard_match u_id_exme (
    .cons(id_ent), .prod(s_exme), .hit(hit_id_exme));
  hazard_match u_id_mewb (
    .cons(id_ent), .prod(s_mewb), .hit(hit_id_mewb));
  hazard_match u_fw_exme (
    .cons(s_idex), .prod(s_exme), .hit(hit_fw_exme));
  hazard_match u_fw_mewb (
    .cons(s_idex), .prod(s_mewb), .hit(hit_fw_mewb));

  always_comb begin
    stall = 1'b0;
    if (FORWARDING != 0) begin
      stall = s_idex.mem_read && (|hit_id_idex);
      if (LOAD_STALL_CYC == 2)
        stall = stall ||
                (s_exme.mem_read && (|hit_id_exme));
    end else begin
      stall = |{hit_id_idex, hit_id_exme, hit_id_mewb};
    end
    stall = stall && id_valid;
  end

  // A load still in EX/ME has no data yet; fall back to ME/WB.
  always_comb begin
    fwd_a_sel = FWD_RF;
    fwd_b_sel = FWD_RF;
    if (FORWARDING != 0) begin
      if (hit_fw_exme[0] && !s_exme.mem_read)
        fwd_a_sel = FWD_EXME;
      else if (hit_fw_mewb[0])
        fwd_a_sel = FWD_MEWB;
      if (hit_fw_exme[1] && !s_exme.mem_read)
        fwd_b_sel = FWD_EXME;
      else if (hit_fw_mewb[1])
        fwd_b_sel = FWD_MEWB;
    end
  end

  assign run      = (state == RUN);
  assign flush    = run && br_taken;
  assign hold     = run && !br_taken && stall;
  assign go       = run && !br_taken && !stall;
  assign stall_go = hold;
  assign busy     = (state != IDLE);
  assign empty    = !(s_idex.valid || s_exme.valid ||
                      s_mewb.valid);

  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b1;
    id_ex_bubble = 1'b1;
    ex_me_flush  = 1'b0;
    unique case (1'b1)
      flush: begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        ex_me_flush = (BRANCH_STAGE == 3);
      end
      hold: begin
        if_id_flush = 1'b0;
      end
      go: begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= IDLE;
      s_idex    <= '0;
      s_exme    <= '0;
      s_mewb    <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      unique case (state)
        IDLE:  if (enable) state <= RUN;
        RUN:   if (!enable) state <= DRAIN;
        DRAIN: begin
          if (enable) state <= RUN;
          else if (empty) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      s_idex <= id_ex_bubble ? '0 : id_ent;
      s_exme <= ex_me_flush ? '0 : s_idex;
      s_mewb <= s_exme;
      if (stall_go && !(&stall_cnt))
        stall_cnt <= stall_cnt + 1'b1;
      if (flush && !(&flush_cnt))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: three parameter variants,
// directed scenarios plus random traffic against a model.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       arst_n = 1'b1;
  logic       enable = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_dest = '0;
  logic       id_use_rs = 0, id_use_rt = 0;
  logic       id_reg_write = 0, id_mem_read = 0;
  logic       br_taken = 1'b0;

  logic        pc_en [3];
  logic        if_id_en [3];
  logic        if_id_flush [3];
  logic        id_ex_bubble [3];
  logic        ex_me_flush [3];
  logic [1:0]  fa [3];
  logic [1:0]  fb [3];
  logic        busy [3];
  logic [15:0] sc [3];
  logic [15:0] fc [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // u0: fwd, 1-cycle load, ME branch; u1: 2-cycle load, EX branch
  // u2: no forwarding, 3-bit counters
  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int CW = (g == 2) ? 3 : 16;
    logic [CW-1:0] sc_l, fc_l;
    assign sc[g] = 16'(sc_l);
    assign fc[g] = 16'(fc_l);
    hazard_ctrl_unit #(
      .REG_ADDR_W(5),
      .FORWARDING(g == 2 ? 0 : 1),
      .LOAD_STALL_CYC(g == 1 ? 2 : 1),
      .BRANCH_STAGE(g == 1 ? 2 : 3),
      .CNT_W(CW)
    ) u_dut (
      .clk(clk), .arst_n(arst_n), .enable(enable),
      .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .id_dest(id_dest), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .br_taken(br_taken),
      .pc_en(pc_en[g]), .if_id_en(if_id_en[g]),
      .if_id_flush(if_id_flush[g]),
      .id_ex_bubble(id_ex_bubble[g]),
      .ex_me_flush(ex_me_flush[g]),
      .fwd_a_sel(fa[g]), .fwd_b_sel(fb[g]),
      .busy(busy[g]), .stall_cnt(sc_l), .flush_cnt(fc_l)
    );
  end

  typedef struct {
    bit v; int rs; int rt; bit urs; bit urt;
    int dst; bit wr; bit ld;
  } ins_t;

  ins_t pipe [3][3];
  int   mst [3];
  int   msc [3];
  int   mfc [3];

  function automatic bit hit(ins_t p, int r, bit u);
    return p.v && p.wr && p.dst == r && r != 0 && u;
  endfunction

  function automatic bit reads(ins_t p, ins_t c);
    return hit(p, c.rs, c.urs) || hit(p, c.rt, c.urt);
  endfunction

  task automatic set_id(input bit v, input int rs, input int rt,
                        input bit urs, input bit urt,
                        input int dst, input bit wr, input bit ld);
    id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt);
    id_use_rs = urs; id_use_rt = urt; id_dest = 5'(dst);
    id_reg_write = wr; id_mem_read = ld;
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    enable = 0; br_taken = 0; nop();
    arst_n = 0; #2; arst_n = 1;
  endtask

  task automatic start();
    do_reset();
    @(negedge clk);
    enable = 1;
  endtask

  task automatic test_reset();
    #1 arst_n = 0;
    #1;
    for (int g = 0; g < 3; g++) begin
      checks++;
      if ({pc_en[g], if_id_en[g], if_id_flush[g],
           id_ex_bubble[g], ex_me_flush[g], fa[g], fb[g],
           busy[g]} !== 9'b0_0_1_1_0_00_00_0) begin
        errors++;
        $display("FAIL reset_ctrl u%0d got %b", g,
          {pc_en[g], if_id_en[g], if_id_flush[g],
           id_ex_bubble[g], ex_me_flush[g], fa[g], fb[g],
           busy[g]});
      end
      checks++;
      if ({sc[g], fc[g]} !== 32'h0) begin
        errors++;
        $display("FAIL reset_cnt u%0d got %h want 0", g,
                 {sc[g], fc[g]});
      end
    end
    #2 arst_n = 1;
  endtask

  task automatic test_fwd_exme();
    start();
    @(negedge clk); set_id(1, 1, 2, 1, 1, 3, 1, 0);
    @(negedge clk); set_id(1, 3, 5, 1, 1, 4, 1, 0);
    #1; checks++;
    if ({pc_en[0], id_ex_bubble[0]} !== 2'b10) begin
      errors++;
      $display("FAIL exme_nostall got %b want 10",
               {pc_en[0], id_ex_bubble[0]});
    end
    @(negedge clk); nop();
    #1; checks++;
    if ({fa[0], fb[0]} !== 4'b01_00) begin
      errors++;
      $display("FAIL exme_fwd got a=%0d b=%0d want 1 0",
               fa[0], fb[0]);
    end
  endtask

  task automatic test_fwd_mewb();
    start();
    @(negedge clk); set_id(1, 1, 2, 1, 1, 3, 1, 0);
    @(negedge clk); nop();
    @(negedge clk); set_id(1, 3, 5, 1, 1, 4, 1, 0);
    @(negedge clk); nop();
    #1; checks++;
    if ({fa[0], fb[0]} !== 4'b10_00) begin
      errors++;
      $display("FAIL mewb_fwd got a=%0d b=%0d want 2 0",
               fa[0], fb[0]);
    end
  endtask

  task automatic test_load_use();
    start();
    @(negedge clk); set_id(1, 0, 0, 1, 0, 3, 1, 1);
    @(negedge clk); set_id(1, 3, 3, 1, 1, 4, 1, 0);
    #1;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if ({pc_en[g], if_id_en[g], id_ex_bubble[g]} !== 3'b001)
      begin
        errors++;
        $display("FAIL lu_stall1 u%0d got %b want 001", g,
                 {pc_en[g], if_id_en[g], id_ex_bubble[g]});
      end
    end
    @(negedge clk); #1;
    checks++;
    if ({pc_en[0], id_ex_bubble[0], pc_en[1], id_ex_bubble[1]}
        !== 4'b10_01) begin
      errors++;
      $display("FAIL lu_stall2 got %b want 1001",
        {pc_en[0], id_ex_bubble[0], pc_en[1], id_ex_bubble[1]});
    end
    @(negedge clk); nop(); #1;
    checks++;
    if ({fa[0], fb[0]} !== 4'b10_10) begin
      errors++;
      $display("FAIL lu_fwd got a=%0d b=%0d want 2 2",
               fa[0], fb[0]);
    end
    checks++;
    if ({sc[0], sc[1]} !== {16'd1, 16'd2}) begin
      errors++;
      $display("FAIL lu_cnt got %0d %0d want 1 2", sc[0], sc[1]);
    end
  endtask

  task automatic test_no_fwd();
    logic [3:0] pcpat;
    logic [1:0] fwdor;
    pcpat = '0;
    fwdor = '0;
    start();
    @(negedge clk); set_id(1, 1, 2, 1, 1, 3, 1, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) set_id(1, 3, 5, 1, 1, 4, 1, 0);
      #1;
      pcpat[i] = pc_en[2];
      fwdor = fwdor | fa[2] | fb[2];
    end
    @(negedge clk); nop(); #1;
    fwdor = fwdor | fa[2] | fb[2];
    checks++;
    if (pcpat !== 4'b1000) begin
      errors++;
      $display("FAIL nofwd_stalls got %b want 1000", pcpat);
    end
    checks++;
    if (sc[2] !== 16'd3) begin
      errors++;
      $display("FAIL nofwd_cnt got %0d want 3", sc[2]);
    end
    checks++;
    if (fwdor !== 2'b00) begin
      errors++;
      $display("FAIL nofwd_sel got %b want 00", fwdor);
    end
  endtask

  task automatic test_reg_zero();
    start();
    @(negedge clk); set_id(1, 1, 2, 1, 1, 0, 1, 1);
    @(negedge clk); set_id(1, 0, 0, 1, 1, 4, 1, 0);
    #1; checks++;
    if ({pc_en[0], pc_en[1], pc_en[2]} !== 3'b111) begin
      errors++;
      $display("FAIL zero_stall got %b want 111",
               {pc_en[0], pc_en[1], pc_en[2]});
    end
    @(negedge clk); nop(); #1;
    checks++;
    if ({fa[0], fb[0], fa[2], fb[2]} !== 8'h00) begin
      errors++;
      $display("FAIL zero_fwd got %b want 0",
               {fa[0], fb[0], fa[2], fb[2]});
    end
  endtask

  task automatic test_flush_over_stall();
    start();
    @(negedge clk); set_id(1, 0, 0, 1, 0, 3, 1, 1);
    @(negedge clk); set_id(1, 3, 3, 1, 1, 4, 1, 0);
    br_taken = 1;
    #1; checks++;
    if ({pc_en[0], if_id_flush[0], id_ex_bubble[0],
         ex_me_flush[0]} !== 4'b1111) begin
      errors++;
      $display("FAIL flush_b3 got %b want 1111",
        {pc_en[0], if_id_flush[0], id_ex_bubble[0],
         ex_me_flush[0]});
    end
    checks++;
    if ({pc_en[1], if_id_flush[1], id_ex_bubble[1],
         ex_me_flush[1]} !== 4'b1110) begin
      errors++;
      $display("FAIL flush_b2 got %b want 1110",
        {pc_en[1], if_id_flush[1], id_ex_bubble[1],
         ex_me_flush[1]});
    end
    @(negedge clk); br_taken = 0; nop(); #1;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if ({fc[g], sc[g]} !== {16'd1, 16'd0}) begin
        errors++;
        $display("FAIL flush_cnt u%0d got f=%0d s=%0d want 1 0",
                 g, fc[g], sc[g]);
      end
    end
  endtask

  task automatic test_drain();
    int n;
    n = 0;
    start();
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); set_id(1, 6, 7, 1, 1, i, 1, 0);
    end
    @(negedge clk); enable = 0; nop();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (i == 0) begin
        checks++;
        if ({pc_en[0], if_id_flush[0], id_ex_bubble[0]}
            !== 3'b011) begin
          errors++;
          $display("FAIL drain_ctrl got %b want 011",
            {pc_en[0], if_id_flush[0], id_ex_bubble[0]});
        end
      end
      if (!busy[0]) break;
      n++;
    end
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL drain_len got %0d want 3", n);
    end
  endtask

  task automatic test_async_reset();
    start();
    @(negedge clk); set_id(1, 0, 0, 1, 0, 3, 1, 1);
    @(negedge clk); set_id(1, 3, 3, 1, 1, 4, 1, 0);
    @(negedge clk); nop(); #1;
    checks++;
    if (sc[0] !== 16'd1) begin
      errors++;
      $display("FAIL pre_reset_cnt got %0d want 1", sc[0]);
    end
    @(posedge clk); #2;
    set_id(1, 3, 3, 1, 1, 4, 1, 0);
    arst_n = 0;
    #1;
    for (int g = 0; g < 3; g++) begin
      checks++;
      if ({pc_en[g], if_id_en[g], if_id_flush[g],
           id_ex_bubble[g], ex_me_flush[g], fa[g], fb[g],
           busy[g], sc[g], fc[g]} !== {9'b0_0_1_1_0_00_00_0,
                                       32'h0}) begin
        errors++;
        $display("FAIL arst_mid u%0d got %b %h", g,
          {pc_en[g], if_id_en[g], if_id_flush[g],
           id_ex_bubble[g], ex_me_flush[g], fa[g], fb[g],
           busy[g]}, {sc[g], fc[g]});
      end
    end
    #1 arst_n = 1;
  endtask

  task automatic test_random();
    ins_t id, e, p0, p1, p2;
    bit en, br, run, stl, fl, fon;
    logic [3:0] ev, ov;
    logic [1:0] ea, eb;
    int cm, lsc, bst;
    e = '{default: 0};
    do_reset();
    for (int g = 0; g < 3; g++) begin
      mst[g] = 0; msc[g] = 0; mfc[g] = 0;
      for (int k = 0; k < 3; k++) pipe[g][k] = e;
    end
    en = 1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) en = !en;
      br = ($urandom_range(0, 11) == 0);
      id.v = ($urandom_range(0, 4) != 0);
      id.rs = $urandom_range(0, 3);
      id.rt = $urandom_range(0, 3);
      id.urs = 1'($urandom_range(0, 1));
      id.urt = 1'($urandom_range(0, 1));
      id.dst = $urandom_range(0, 3);
      id.wr = ($urandom_range(0, 4) != 0);
      id.ld = ($urandom_range(0, 2) == 0);
      enable = en; br_taken = br;
      set_id(id.v, id.rs, id.rt, id.urs, id.urt,
             id.dst, id.wr, id.ld);
      #1;
      for (int g = 0; g < 3; g++) begin
        fon = (g != 2);
        lsc = (g == 1) ? 2 : 1;
        bst = (g == 1) ? 2 : 3;
        cm  = (g == 2) ? 7 : 65535;
        p0 = pipe[g][0]; p1 = pipe[g][1]; p2 = pipe[g][2];
        run = (mst[g] == 1);
        if (fon)
          stl = (p0.ld && reads(p0, id)) ||
                (lsc == 2 && p1.ld && reads(p1, id));
        else
          stl = reads(p0, id) || reads(p1, id) || reads(p2, id);
        stl = stl && id.v;
        fl = run && br;
        ev = {run && (fl || !stl), !run || fl,
              !run || fl || stl, fl && bst == 3};
        ea = 2'd0; eb = 2'd0;
        if (fon && p0.v) begin
          if (hit(p1, p0.rs, p0.urs) && !p1.ld) ea = 2'd1;
          else if (hit(p2, p0.rs, p0.urs)) ea = 2'd2;
          if (hit(p1, p0.rt, p0.urt) && !p1.ld) eb = 2'd1;
          else if (hit(p2, p0.rt, p0.urt)) eb = 2'd2;
        end
        ov = {pc_en[g], if_id_flush[g], id_ex_bubble[g],
              ex_me_flush[g]};
        checks++;
        if (ov !== ev) begin
          errors++;
          $display("FAIL rnd_ctrl u%0d c%0d got %b want %b",
                   g, c, ov, ev);
        end
        if (!fl) begin
          checks++;
          if (if_id_en[g] !== (run && !stl)) begin
            errors++;
            $display("FAIL rnd_ifid u%0d c%0d got %b want %b",
                     g, c, if_id_en[g], run && !stl);
          end
        end
        checks++;
        if ({fa[g], fb[g]} !== {ea, eb}) begin
          errors++;
          $display("FAIL rnd_fwd u%0d c%0d got %0d %0d want %0d %0d",
                   g, c, fa[g], fb[g], ea, eb);
        end
        checks++;
        if (busy[g] !== (mst[g] != 0)) begin
          errors++;
          $display("FAIL rnd_busy u%0d c%0d got %b want %b",
                   g, c, busy[g], mst[g] != 0);
        end
        checks++;
        if ({sc[g], fc[g]} !== {16'(msc[g]), 16'(mfc[g])}) begin
          errors++;
          $display("FAIL rnd_cnt u%0d c%0d got %0d %0d want %0d %0d",
                   g, c, sc[g], fc[g], msc[g], mfc[g]);
        end
        if (run && stl && !fl && msc[g] < cm) msc[g]++;
        if (fl && mfc[g] < cm) mfc[g]++;
        case (mst[g])
          0: if (en) mst[g] = 1;
          1: if (!en) mst[g] = 2;
          default: begin
            if (en) mst[g] = 1;
            else if (!(p0.v || p1.v || p2.v)) mst[g] = 0;
          end
        endcase
        pipe[g][2] = p1;
        pipe[g][1] = ev[0] ? e : p0;
        pipe[g][0] = (ev[1] || !id.v) ? e : id;
      end
    end
    enable = 0; br_taken = 0; nop();
  endtask

  initial begin
    test_reset();
    test_fwd_exme();
    test_fwd_mewb();
    test_load_use();
    test_no_fwd();
    test_reg_zero();
    test_flush_over_stall();
    test_drain();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
